booth_r4_mul: RTL and testbench

//  Parametrised radix-4 Booth sequential multiplier: next generation of the

---
 rtl/booth_r4_mul.sv | 150 +++++++++++++++
 tb/tb_booth_r4_mul.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mul.sv
// ---------------------------------------------------------------------------
// booth_r4_mul
// Sequential radix-4 Booth multiplier with per-operation signed/unsigned mode.
// It retires two multiplier bits per cycle and uses one extra digit so that
// the top bit of an unsigned operand is covered.
//
// Ports
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   op_start     : start request, honoured only in IDLE
//   op_clear     : synchronous abort/clear, highest priority in every state
//   op_signed    : 1 = two's-complement operands, 0 = unsigned (latched at start)
//   multiplier   : operand A (latched at start)
//   multiplicand : operand B (latched at start)
//   op_busy      : high while Booth iterations are outstanding
//   op_done      : high while the product is held in DONE
//   mul_result   : registered 2W-bit product, valid while op_done = 1
// ---------------------------------------------------------------------------
module booth_r4_mul #(
    parameter int W  = 32,
    parameter int CW = 7
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           op_start,
    input  logic           op_clear,
    input  logic           op_signed,
    input  logic [W-1:0]   multiplier,
    input  logic [W-1:0]   multiplicand,
    output logic           op_busy,
    output logic           op_done,
    output logic [2*W-1:0] mul_result
);

    // Accumulator layout: {upper partial sum (W+2), multiplier (W+2), guard}
    localparam int XW = W + 2;
    localparam int AW = 2 * XW + 1;
    localparam logic [CW-1:0] N_ITER = CW'(W / 2 + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EXEC    = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    counter_reg, counter_next;
    logic [AW-1:0]    acc_reg, acc_next;
    logic [XW-1:0]    b_reg, b_next;
    logic [2*W-1:0]   result_reg, result_next;

    // Booth recoding and W+2-bit add/subtract datapath
    logic [XW-1:0]    a_ext, b_ext, b_dbl, pp, addend, sum;
    logic             neg;
    logic [AW-1:0]    acc_added, acc_shifted;

    assign a_ext = op_signed ? {{2{multiplier[W-1]}}, multiplier}   : {2'b00, multiplier};
    assign b_ext = op_signed ? {{2{multiplicand[W-1]}}, multiplicand} : {2'b00, multiplicand};
    assign b_dbl = {b_reg[XW-2:0], 1'b0};

    always_comb begin
        pp  = '0;
        neg = 1'b0;
        unique case (acc_reg[2:0])
            3'b001, 3'b010: pp = b_reg;
            3'b011:         pp = b_dbl;
            3'b100: begin
                pp  = b_dbl;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                pp  = b_reg;
                neg = 1'b1;
            end
            default: begin
                pp  = '0;
                neg = 1'b0;
            end
        endcase
    end

    // Subtraction as ~pp + 1; the carry out of the W+2-bit sum is dropped.
    assign addend      = neg ? ~pp : pp;
    assign sum         = acc_reg[AW-1:XW+1] + addend + XW'(neg);
    assign acc_added   = {sum, acc_reg[XW:0]};
    assign acc_shifted = {{2{sum[XW-1]}}, acc_added[AW-1:2]};

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        acc_next     = acc_reg;
        b_next       = b_reg;
        result_next  = result_reg;

        if (op_clear) begin
            state_next   = IDLE;
            counter_next = '0;
            result_next  = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (op_start) begin
                        acc_next     = {{XW{1'b0}}, a_ext, 1'b0};
                        b_next       = b_ext;
                        counter_next = '0;
                        state_next   = EXEC;
                    end
                end
                EXEC: begin
                    // The cycle after the last iteration writes the product back.
                    if (counter_reg == N_ITER) begin
                        result_next = acc_reg[2*W:1];
                        state_next  = DONE;
                    end else begin
                        acc_next     = acc_shifted;
                        counter_next = counter_reg + CW'(1);
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            acc_reg     <= '0;
            b_reg       <= '0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            acc_reg     <= acc_next;
            b_reg       <= b_next;
            result_reg  <= result_next;
        end
    end

    assign op_busy    = (state_reg == EXEC) && (counter_reg != N_ITER);
    assign op_done    = (state_reg == DONE);
    assign mul_result = result_reg;

endmodule

// File: tb/tb_booth_r4_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_mul
// Bench for booth_r4_mul: a W=32 instance checked every cycle against a
// transaction-level model, plus a W=8 instance checked per operation.
// ---------------------------------------------------------------------------
module tb_booth_r4_mul;

    localparam int N32 = 17;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_start, op_clear, op_signed;
    logic [31:0] multiplier, multiplicand;
    logic        op_busy, op_done;
    logic [63:0] mul_result;

    logic        start8, clear8, signed8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] res8;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    booth_r4_mul #(.W(32), .CW(7)) dut (
        .clk(clk), .reset_n(rst_n), .op_start(op_start), .op_clear(op_clear),
        .op_signed(op_signed), .multiplier(multiplier), .multiplicand(multiplicand),
        .op_busy(op_busy), .op_done(op_done), .mul_result(mul_result)
    );

    booth_r4_mul #(.W(8), .CW(4)) dut8 (
        .clk(clk), .reset_n(rst_n), .op_start(start8), .op_clear(clear8),
        .op_signed(signed8), .multiplier(a8), .multiplicand(b8),
        .op_busy(busy8), .op_done(done8), .mul_result(res8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    function automatic logic [15:0] ref_mul8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ia, ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        return 16'(ia * ib);
    endfunction

    // Transaction model of the W=32 unit: phase, edges since start, product.
    int          m_phase;   // 0 idle, 1 running, 2 done
    int          m_t;
    logic [63:0] m_prod, m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_t     <= 0;
            m_res   <= '0;
            m_prod  <= '0;
        end else if (op_clear) begin
            m_phase <= 0;
            m_t     <= 0;
            m_res   <= '0;
        end else if (m_phase == 0) begin
            if (op_start) begin
                m_prod  <= ref_mul(multiplier, multiplicand, op_signed);
                m_t     <= 0;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            // Result appears N+1 edges after the start edge.
            m_t <= m_t + 1;
            if (m_t + 1 == N32 + 1) begin
                m_phase <= 2;
                m_res   <= m_prod;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_busy",   64'(op_busy), 64'(m_phase == 1 && m_t < N32));
            check("cyc_done",   64'(op_done), 64'(m_phase == 2));
            check("cyc_result", mul_result, m_res);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] res, output int edges, output int busy_cnt);
        @(negedge clk);
        multiplier = a; multiplicand = b; op_signed = s; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        multiplier = $urandom; multiplicand = $urandom; op_signed = 1'($urandom);
        edges = 0; busy_cnt = 0;
        if (op_busy) busy_cnt++;
        while (!op_done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (op_busy) busy_cnt++;
        end
        if (!op_done) check("timeout32", 64'(edges), 64'(N32 + 1));
        res = mul_result;
        $display("op32 a=%h b=%h s=%0d -> %h after %0d edges", a, b, s, res, edges);
    endtask

    task automatic clear_op();
        @(negedge clk); op_clear = 1'b1;
        @(posedge clk); #1; op_clear = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] res, output int edges);
        @(negedge clk);
        a8 = a; b8 = b; signed8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        edges = 0;
        while (!done8 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!done8) check("timeout8", 64'(edges), 64'd6);
        res = res8;
        @(negedge clk); clear8 = 1'b1;
        @(posedge clk); #1; clear8 = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        logic [15:0] r8;
        logic [31:0] ra, rb;
        logic        rs;
        int          e, bc;

        rst_n = 1'b0;
        op_start = 0; op_clear = 0; op_signed = 0; multiplier = 0; multiplicand = 0;
        start8 = 0; clear8 = 0; signed8 = 0; a8 = 0; b8 = 0;
        #12;
        check("rst_busy", 64'(op_busy), 64'd0);
        check("rst_done", 64'(op_done), 64'd0);
        check("rst_result", mul_result, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Model pins
        check("model_u_ff", ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0), 64'hFFFFFFFE00000001);
        check("model_s_min", ref_mul(32'h80000000, 32'h80000000, 1'b1), 64'h4000000000000000);
        check("model8_u", 64'(ref_mul8(8'hFF, 8'h80, 1'b0)), 64'h7F80);
        check("model8_s", 64'(ref_mul8(8'hFF, 8'h80, 1'b1)), 64'h0080);

        // Unsigned max, latency and busy length
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, e, bc);
        check("t1_result", r, 64'hFFFFFFFE00000001);
        check("t1_latency", 64'(e), 64'd18);
        check("t1_busy_cycles", 64'(bc), 64'd17);
        // op_start while DONE is ignored
        @(negedge clk); op_start = 1'b1; multiplier = 32'd3; multiplicand = 32'd5;
        @(posedge clk); #1; op_start = 1'b0;
        check("done_start_done", 64'(op_done), 64'd1);
        check("done_start_result", mul_result, 64'hFFFFFFFE00000001);
        clear_op();

        // Signed extremes
        run_op(32'h80000000, 32'h80000000, 1'b1, r, e, bc);
        check("t2_min_min", r, 64'h4000000000000000);
        clear_op();
        run_op(32'hFFFFFFFD, 32'd7, 1'b1, r, e, bc);
        check("t2_m3_x7", r, 64'hFFFFFFFFFFFFFFEB);
        clear_op();

        // Randomized operations; per-cycle checking by the compare process
        for (int i = 0; i < 150; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            if (i % 10 == 0) ra = 32'h80000000;
            if (i % 10 == 1) rb = 32'hFFFFFFFF;
            if (i % 10 == 2) ra = 32'h7FFFFFFF;
            run_op(ra, rb, rs, r, e, bc);
            check("rand32", r, ref_mul(ra, rb, rs));
            clear_op();
        end

        // op_clear in the middle of EXEC
        @(negedge clk); multiplier = 32'd123456; multiplicand = 32'hFFFFFCEB;
        op_signed = 1'b1; op_start = 1'b1;
        @(posedge clk); #1; op_start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); op_clear = 1'b1;
        @(posedge clk); #1; op_clear = 1'b0;
        check("clr_busy", 64'(op_busy), 64'd0);
        check("clr_result", mul_result, 64'd0);
        run_op(32'd1000, 32'hFFFFFFFF, 1'b1, r, e, bc);
        check("clr_then_op", r, 64'hFFFFFFFFFFFFFC18);
        clear_op();

        // op_start together with op_clear in IDLE
        @(negedge clk); op_start = 1'b1; op_clear = 1'b1;
        @(posedge clk); #1; op_start = 1'b0; op_clear = 1'b0;
        check("start_clr_busy", 64'(op_busy), 64'd0);
        @(posedge clk); #1;
        check("start_clr_busy2", 64'(op_busy), 64'd0);

        // Asynchronous reset mid-EXEC, away from the clock edge
        @(negedge clk); multiplier = 32'd77; multiplicand = 32'd99; op_signed = 0; op_start = 1'b1;
        @(posedge clk); #1; op_start = 1'b0;
        repeat (6) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check("arst_busy", 64'(op_busy), 64'd0);
        check("arst_done", 64'(op_done), 64'd0);
        check("arst_result", mul_result, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(32'd77, 32'd99, 1'b0, r, e, bc);
        check("arst_then_op", r, 64'd7623);
        clear_op();

        // W=8 instance: literal corners, then randomized pairs in both modes
        run8(8'hFF, 8'h80, 1'b0, r8, e);
        check("w8_u_ff_80", 64'(r8), 64'h7F80);
        check("w8_latency", 64'(e), 64'd6);
        run8(8'hFF, 8'h80, 1'b1, r8, e);
        check("w8_s_ff_80", 64'(r8), 64'h0080);
        run8(8'h80, 8'h80, 1'b1, r8, e);
        check("w8_s_min_min", 64'(r8), 64'h4000);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 250; i++) begin
                logic [7:0] x, y;
                x = 8'($urandom); y = 8'($urandom);
                run8(x, y, 1'(m), r8, e);
                $display("op8 a=%h b=%h s=%0d -> %h", x, y, m, r8);
                check("rand8", 64'(r8), 64'(ref_mul8(x, y, 1'(m))));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
